// File: rtl/prog_loader.sv
// Framed program loader: receives a length byte, packed payload and XOR checksum
// from the UART and writes the decoded words into the CPU register memory.
module prog_loader #(
  parameter int REGISTER_WIDTH       = 4,
  parameter int MEMORY_REGISTERS     = 16,
  parameter int MEMORY_ADDRESS_WIDTH = 4,
  parameter bit MSB_FIRST            = 1'b1,
  parameter bit ZERO_FILL            = 1'b1
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            p_program_i,
  input  logic [7:0]                      rx_data_i,
  input  logic                            rx_valid_i,
  output logic                            mem_we_o,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [REGISTER_WIDTH-1:0]       mem_data_o,
  output logic                            program_o,
  output logic                            done_o,
  output logic [1:0]                      error_o
);

  // Counters carry one extra bit so they can hold the full depth as a value.
  localparam int CW = MEMORY_ADDRESS_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = CW'(MEMORY_REGISTERS);
  localparam bit TWO_WORDS = (REGISTER_WIDTH == 4);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_LEN   = 2'd1;
  localparam logic [1:0] ERR_CSUM  = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_PAYLOAD, S_WRITE, S_CHECK, S_FILL, S_DONE, S_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic            prev_prog_q;
  logic [CW-1:0]   len_q, nleft_q, widx_q;
  logic [7:0]      csum_q, byte_q;
  logic            sel_q;

  logic                      start, abort, len_bad, csum_ok, last_word;
  logic [1:0]                err_kind, err_d;
  logic [CW-1:0]             len_in, nbytes_in, addr_d;
  logic                      we_d, prog_d, done_d;
  logic [REGISTER_WIDTH-1:0] data_d, first_word, second_word;

  assign start   = p_program_i && !prev_prog_q && (state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign abort   = !p_program_i && (state_q inside {S_LEN, S_PAYLOAD, S_WRITE, S_CHECK});
  assign len_bad = (rx_data_i == 8'd0) || (rx_data_i > 8'(MEMORY_REGISTERS));
  assign csum_ok = (rx_data_i == csum_q);
  assign last_word = !TWO_WORDS || sel_q;

  assign len_in    = rx_data_i[CW-1:0];
  assign nbytes_in = TWO_WORDS ? ((len_in + CW'(1)) >> 1) : len_in;

  // At width 8 both selections collapse to the whole byte.
  assign first_word  = MSB_FIRST ? rx_data_i[7 -: REGISTER_WIDTH] : rx_data_i[REGISTER_WIDTH-1:0];
  assign second_word = MSB_FIRST ? byte_q[REGISTER_WIDTH-1:0] : byte_q[7 -: REGISTER_WIDTH];

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset_i) begin
      state_q     <= S_IDLE;
      prev_prog_q <= 1'b0;
      len_q       <= '0;
      nleft_q     <= '0;
      widx_q      <= '0;
      csum_q      <= '0;
      byte_q      <= '0;
      sel_q       <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      program_o   <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      prev_prog_q <= p_program_i;
      mem_we_o    <= we_d;
      mem_addr_o  <= addr_d[MEMORY_ADDRESS_WIDTH-1:0];
      mem_data_o  <= data_d;
      program_o   <= prog_d;
      done_o      <= done_d;
      error_o     <= err_d;

      if (start) begin
        widx_q <= '0;
        csum_q <= '0;
        sel_q  <= 1'b0;
      end
      if (state_q == S_LEN && state_d == S_PAYLOAD) begin
        len_q   <= len_in;
        nleft_q <= nbytes_in;
        csum_q  <= rx_data_i;
      end
      if (state_q == S_PAYLOAD && state_d == S_WRITE) begin
        byte_q  <= rx_data_i;
        csum_q  <= csum_q ^ rx_data_i;
        nleft_q <= nleft_q - CW'(1);
        widx_q  <= widx_q + CW'(1);
        sel_q   <= 1'b0;
      end
      if (state_q == S_WRITE && state_d == S_WRITE) begin
        widx_q <= widx_q + CW'(1);
        sel_q  <= 1'b1;
      end
      if (state_q == S_CHECK && state_d == S_FILL) widx_q <= len_q + CW'(1);
      if (state_q == S_FILL && state_d == S_FILL)  widx_q <= widx_q + CW'(1);
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable unassigned.
    state_d  = state_q;
    err_kind = ERR_ABORT;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN;
      S_LEN: begin
        if (abort) state_d = S_ERROR;
        else if (rx_valid_i) begin
          if (len_bad) begin
            state_d  = S_ERROR;
            err_kind = ERR_LEN;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (abort)           state_d = S_ERROR;
        else if (rx_valid_i) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (abort || rx_valid_i) state_d = S_ERROR;
        else if (last_word)      state_d = (nleft_q == '0) ? S_CHECK : S_PAYLOAD;
      end
      S_CHECK: begin
        if (abort) state_d = S_ERROR;
        else if (rx_valid_i) begin
          if (csum_ok) begin
            state_d = (ZERO_FILL && len_q != DEPTH) ? S_FILL : S_DONE;
          end else begin
            state_d  = S_ERROR;
            err_kind = ERR_CSUM;
          end
        end
      end
      S_FILL: begin
        if (rx_valid_i)            state_d = S_ERROR;
        else if (widx_q == DEPTH)  state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead and registered, so writes only
  // appear while the next state still intends to write.
  always_comb begin
    we_d   = 1'b0;
    addr_d = widx_q;
    data_d = '0;
    if (state_q == S_PAYLOAD && state_d == S_WRITE) begin
      we_d   = 1'b1;
      data_d = first_word;
    end else if (state_q == S_WRITE && state_d == S_WRITE) begin
      we_d   = (widx_q < len_q);
      data_d = second_word;
    end else if (state_q == S_CHECK && state_d == S_FILL) begin
      we_d   = 1'b1;
      addr_d = len_q;
    end else if (state_q == S_FILL && state_d == S_FILL) begin
      we_d   = 1'b1;
    end
    prog_d = (state_d inside {S_LEN, S_PAYLOAD, S_WRITE, S_CHECK, S_FILL});
    done_d = (state_d == S_DONE);
    err_d  = ERR_NONE;
    if (state_d == S_ERROR) err_d = (state_q == S_ERROR) ? error_o : err_kind;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: default 4-bit/16-deep instance plus an
// 8-bit/8-deep instance without zero fill.
module tb_prog_loader;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  logic       a_prog = 1'b0, a_rx_valid = 1'b0;
  logic [7:0] a_rx_data = 8'h00;
  logic       a_we, a_program, a_done;
  logic [3:0] a_addr, a_data;
  logic [1:0] a_error;

  logic       b_prog = 1'b0, b_rx_valid = 1'b0;
  logic [7:0] b_rx_data = 8'h00;
  logic       b_we, b_program, b_done;
  logic [2:0] b_addr;
  logic [7:0] b_data;
  logic [1:0] b_error;

  prog_loader dut_a (
    .clk_i(clk), .reset_i(reset_i), .p_program_i(a_prog),
    .rx_data_i(a_rx_data), .rx_valid_i(a_rx_valid),
    .mem_we_o(a_we), .mem_addr_o(a_addr), .mem_data_o(a_data),
    .program_o(a_program), .done_o(a_done), .error_o(a_error)
  );

  prog_loader #(
    .REGISTER_WIDTH(8), .MEMORY_REGISTERS(8), .MEMORY_ADDRESS_WIDTH(3),
    .MSB_FIRST(1'b1), .ZERO_FILL(1'b0)
  ) dut_b (
    .clk_i(clk), .reset_i(reset_i), .p_program_i(b_prog),
    .rx_data_i(b_rx_data), .rx_valid_i(b_rx_valid),
    .mem_we_o(b_we), .mem_addr_o(b_addr), .mem_data_o(b_data),
    .program_o(b_program), .done_o(b_done), .error_o(b_error)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  string log_a = "";
  string log_b = "";

  // Write logs, sampled mid-cycle.
  always @(negedge clk) begin
    if (a_we) log_a = {log_a, $sformatf("%0h@%0d ", a_data, a_addr)};
    if (b_we) log_b = {log_b, $sformatf("%0h@%0d ", b_data, b_addr)};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic string fill_str(input int lo, input int hi);
    string s = "";
    for (int i = lo; i <= hi; i++) s = {s, $sformatf("0@%0d ", i)};
    return s;
  endfunction

  task automatic a_restart();
    a_prog = 1'b0;
    tick();
    a_prog = 1'b1;
    tick();
  endtask

  task automatic a_send(input logic [7:0] b);
    a_rx_data  = b;
    a_rx_valid = 1'b1;
    tick();
    a_rx_valid = 1'b0;
    tick();
    tick();
  endtask

  // Strobe a byte and count cycles until done_o or error_o rises (-1 on timeout).
  task automatic a_finish(input logic [7:0] b, output int cyc);
    bit ended = 1'b0;
    a_rx_data  = b;
    a_rx_valid = 1'b1;
    cyc = 0;
    while (!ended && cyc < 40) begin
      tick();
      a_rx_valid = 1'b0;
      cyc++;
      if (a_done || a_error != 2'd0) ended = 1'b1;
    end
    if (!ended) cyc = -1;
  endtask

  task automatic b_send(input logic [7:0] b);
    b_rx_data  = b;
    b_rx_valid = 1'b1;
    tick();
    b_rx_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({a_we, a_addr, a_data, a_program, a_done, a_error} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_a: got %0h expected 0", {a_we, a_addr, a_data, a_program, a_done, a_error});
    end
    n_checks++;
    if ({b_we, b_addr, b_data, b_program, b_done, b_error} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_b: got %0h expected 0", {b_we, b_addr, b_data, b_program, b_done, b_error});
    end
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_good_even();
    int    cyc;
    string exp;
    a_restart();
    n_checks++;
    if (a_program !== 1'b1) begin
      n_fail++;
      $display("FAIL start_program: got %0b expected 1", a_program);
    end
    log_a = "";
    a_send(8'h04);
    a_rx_data  = 8'hF0;
    a_rx_valid = 1'b1;
    tick();
    a_rx_valid = 1'b0;
    n_checks++;
    if ({a_we, a_addr, a_data} !== {1'b1, 4'd0, 4'hF}) begin
      n_fail++;
      $display("FAIL first_word: got we/addr/data %0h expected 10f", {a_we, a_addr, a_data});
    end
    tick();
    n_checks++;
    if ({a_we, a_addr, a_data} !== {1'b1, 4'd1, 4'h0}) begin
      n_fail++;
      $display("FAIL second_word: got we/addr/data %0h expected 110", {a_we, a_addr, a_data});
    end
    tick();
    n_checks++;
    if (a_we !== 1'b0) begin
      n_fail++;
      $display("FAIL write_gap: got we %0b expected 0", a_we);
    end
    a_send(8'hE5);
    a_finish(8'h11, cyc);
    n_checks++;
    if (cyc !== 13) begin
      n_fail++;
      $display("FAIL even_done_latency: got %0d cycles expected 13", cyc);
    end
    n_checks++;
    if ({a_done, a_error, a_program} !== {1'b1, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL even_status: got done/err/prog %0b %0d %0b expected 1 0 0", a_done, a_error, a_program);
    end
    exp = {"f@0 0@1 e@2 5@3 ", fill_str(4, 15)};
    n_checks++;
    if (log_a != exp) begin
      n_fail++;
      $display("FAIL even_writes: got '%s' expected '%s'", log_a, exp);
    end
  endtask

  task automatic test_odd_length();
    int    cyc;
    string exp;
    a_restart();
    log_a = "";
    a_send(8'h03);
    a_send(8'hDE);
    a_send(8'h80);
    a_finish(8'h5D, cyc);
    n_checks++;
    if (cyc !== 14 || a_done !== 1'b1 || a_error !== 2'd0) begin
      n_fail++;
      $display("FAIL odd_done: got cyc %0d done %0b err %0d expected 14 1 0", cyc, a_done, a_error);
    end
    exp = {"d@0 e@1 8@2 ", fill_str(3, 15)};
    n_checks++;
    if (log_a != exp) begin
      n_fail++;
      $display("FAIL odd_writes: got '%s' expected '%s'", log_a, exp);
    end
  endtask

  task automatic test_bad_checksum();
    int cyc;
    a_restart();
    log_a = "";
    a_send(8'h04);
    a_send(8'hF0);
    a_send(8'hE5);
    a_finish(8'h12, cyc);
    n_checks++;
    if (cyc !== 1 || a_error !== 2'd2 || a_done !== 1'b0) begin
      n_fail++;
      $display("FAIL csum_error: got cyc %0d err %0d done %0b expected 1 2 0", cyc, a_error, a_done);
    end
    repeat (5) tick();
    n_checks++;
    if (log_a != "f@0 0@1 e@2 5@3 " || a_error !== 2'd2) begin
      n_fail++;
      $display("FAIL csum_no_fill: got '%s' err %0d expected 'f@0 0@1 e@2 5@3 ' err 2", log_a, a_error);
    end
  endtask

  task automatic test_bad_length();
    int cyc;
    a_restart();
    n_checks++;
    if (a_error !== 2'd0 || a_program !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clears: got err %0d prog %0b expected 0 1", a_error, a_program);
    end
    log_a = "";
    a_finish(8'h00, cyc);
    n_checks++;
    if (cyc !== 1 || a_error !== 2'd1 || a_program !== 1'b0) begin
      n_fail++;
      $display("FAIL len_zero: got cyc %0d err %0d prog %0b expected 1 1 0", cyc, a_error, a_program);
    end
    a_restart();
    n_checks++;
    if (a_error !== 2'd0) begin
      n_fail++;
      $display("FAIL len_restart: got err %0d expected 0", a_error);
    end
    a_finish(8'h11, cyc);
    n_checks++;
    if (cyc !== 1 || a_error !== 2'd1) begin
      n_fail++;
      $display("FAIL len_too_big: got cyc %0d err %0d expected 1 1", cyc, a_error);
    end
    repeat (3) tick();
    n_checks++;
    if (log_a != "") begin
      n_fail++;
      $display("FAIL len_no_writes: got '%s' expected ''", log_a);
    end
  endtask

  task automatic test_abort();
    a_restart();
    log_a = "";
    a_send(8'h04);
    a_send(8'hF0);
    a_prog = 1'b0;
    tick();
    n_checks++;
    if (a_error !== 2'd3 || a_program !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_status: got err %0d prog %0b expected 3 0", a_error, a_program);
    end
    repeat (4) tick();
    n_checks++;
    if (log_a != "f@0 0@1 ") begin
      n_fail++;
      $display("FAIL abort_writes: got '%s' expected 'f@0 0@1 '", log_a);
    end
  endtask

  task automatic test_overrun();
    a_restart();
    log_a = "";
    a_send(8'h04);
    a_rx_data  = 8'hF0;
    a_rx_valid = 1'b1;
    tick();
    a_rx_data  = 8'h77;
    tick();
    a_rx_valid = 1'b0;
    n_checks++;
    if (a_error !== 2'd3 || a_we !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_status: got err %0d we %0b expected 3 0", a_error, a_we);
    end
    repeat (3) tick();
    n_checks++;
    if (log_a != "f@0 ") begin
      n_fail++;
      $display("FAIL overrun_writes: got '%s' expected 'f@0 '", log_a);
    end
  endtask

  task automatic test_reset_mid_payload();
    a_restart();
    log_a = "";
    a_send(8'h04);
    a_rx_data  = 8'hF0;
    a_rx_valid = 1'b1;
    tick();
    a_rx_valid = 1'b0;
    reset_i = 1'b1;
    a_prog  = 1'b0;
    tick();
    n_checks++;
    if ({a_we, a_addr, a_data, a_program, a_done, a_error} !== 13'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %0h expected 0", {a_we, a_addr, a_data, a_program, a_done, a_error});
    end
    reset_i = 1'b0;
    a_send(8'hE5);
    a_send(8'h11);
    n_checks++;
    if (log_a != "f@0 " || a_program !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_writes: got '%s' prog %0b expected 'f@0 ' 0", log_a, a_program);
    end
  endtask

  task automatic test_width8();
    int cyc = 0;
    bit ended = 1'b0;
    b_prog = 1'b0;
    tick();
    b_prog = 1'b1;
    tick();
    log_b = "";
    b_send(8'h02);
    b_send(8'hAB);
    b_send(8'hCD);
    b_rx_data  = 8'h64;
    b_rx_valid = 1'b1;
    while (!ended && cyc < 40) begin
      tick();
      b_rx_valid = 1'b0;
      cyc++;
      if (b_done || b_error != 2'd0) ended = 1'b1;
    end
    n_checks++;
    if (cyc !== 1 || b_done !== 1'b1 || b_error !== 2'd0) begin
      n_fail++;
      $display("FAIL w8_done: got cyc %0d done %0b err %0d expected 1 1 0", cyc, b_done, b_error);
    end
    repeat (3) tick();
    n_checks++;
    if (log_b != "ab@0 cd@1 ") begin
      n_fail++;
      $display("FAIL w8_writes: got '%s' expected 'ab@0 cd@1 '", log_b);
    end
  endtask

  initial begin
    test_reset();
    test_good_even();
    test_odd_length();
    test_bad_checksum();
    test_bad_length();
    test_abort();
    test_overrun();
    test_reset_mid_payload();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Parametrised successor to the single-mode programmer: a framed program loader that takes bytes from `uart_rx` and writes words into the CPU's register memory. It sits between `uart_rx` and `reg_memory` inside `cpu`. Each frame carries a length header, the packed payload and an XOR checksum. It adds configurable word width, depth, nibble order, zero-fill of unused memory, and error reporting.

## Interface

**Parameters**
- `REGISTER_WIDTH`, default 4: memory word width. Legal values are 4 and 8 only.
- `MEMORY_REGISTERS`, default 16: memory depth in words.
- `MEMORY_ADDRESS_WIDTH`, default 4: address width. Must equal clog2(`MEMORY_REGISTERS`).
- `MSB_FIRST`, default 1: at width 4, the high nibble of each byte goes to the lower address.
- `ZERO_FILL`, default 1: after a good frame, write 0 (NOP) to every address from L to `MEMORY_REGISTERS`-1.

**Ports**
- `clk_i`, in, 1: system clock.
- `reset_i`, in, 1: reset. Synchronous, active-high.
- `p_program_i`, in, 1: program request. Its rising edge starts a frame.
- `rx_data_i`, in, 8: received byte from `uart_rx`.
- `rx_valid_i`, in, 1: one-cycle strobe. Qualifies `rx_data_i`.
- `mem_we_o`, out, 1: memory write enable.
- `mem_addr_o`, out, `MEMORY_ADDRESS_WIDTH`: write address.
- `mem_data_o`, out, `REGISTER_WIDTH`: write data.
- `program_o`, out, 1: loader busy. The CPU holds in fetch while this is high.
- `done_o`, out, 1: last frame loaded successfully. Level signal.
- `error_o`, out, 2: 0 = none, 1 = bad length, 2 = checksum mismatch, 3 = abort/overrun.

## Operation

**Reset**
- Next state is IDLE.
- All outputs go to 0.
- Internal address, counter, checksum and edge-detect registers are cleared.

**States:** IDLE, LEN, PAYLOAD, WRITE, CHECK, FILL, DONE, ERROR.

**Start**
- A `p_program_i` rising edge (registered previous value 0, current value 1) moves the loader to LEN.
- This is honoured from IDLE, DONE or ERROR.
- On entry: `done_o` and `error_o` clear, address is 0, checksum is 0.

**LEN**
- On `rx_valid_i`, the byte is taken as word count L and becomes the checksum seed.
- If L is 0 or L > `MEMORY_REGISTERS`: go to ERROR with code 1.
- Otherwise go to PAYLOAD. Payload byte count N = L at width 8, or ceil(L/2) at width 4.

**PAYLOAD**
- On `rx_valid_i`: latch the byte, XOR it into the checksum, decrement N, go to WRITE.

**WRITE**
- Issues one write per word held in the byte: 1 word at width 8, 2 words at width 4.
- Address increments after each write.
- A word whose index is ≥ L is not written (this is the low word of the last byte when L is odd).
- When done, go to PAYLOAD if N > 0, otherwise to CHECK.

**CHECK**
- On `rx_valid_i`: if the byte equals the checksum, go to FILL (when `ZERO_FILL`=1) or DONE; otherwise go to ERROR with code 2.

**FILL**
- Writes 0 to address L, then L+1, and so on, one per cycle.
- After address `MEMORY_REGISTERS`-1, go to DONE.
- If L equals the depth, go straight to DONE.

**Outputs by state**
- `program_o` is 1 in LEN, PAYLOAD, WRITE, CHECK and FILL.
- DONE: `done_o` = 1 and holds until the next start.
- ERROR: `error_o` holds its code until the next start. No further writes are issued.

**Abort and overrun**
- `p_program_i` sampled low in LEN, PAYLOAD, WRITE or CHECK: go to ERROR with code 3.
- `rx_valid_i` during WRITE or FILL: overrun, go to ERROR with code 3. The byte is dropped.
- On either, no `mem_we_o` is issued after the detecting cycle.
- `p_program_i` falling in DONE or ERROR has no effect.

**Ignored inputs**
- `rx_valid_i` in IDLE, DONE or ERROR is ignored.
- Address arithmetic is modulo 2^`MEMORY_ADDRESS_WIDTH`. Writes never exceed `MEMORY_REGISTERS`-1.

## Timing

- All outputs are registered.
- **Start:** start edge sampled at cycle t, so LEN and `program_o` = 1 at t+1.
- **Payload write:** payload byte strobed at cycle t.
  - First word: `mem_we_o` at t+1.
  - Second word (width 4): at t+2.
  - PAYLOAD is re-entered at t+2 (width 8) or t+3 (width 4).
- **Checksum byte** strobed at cycle t:
  - Success without fill: `done_o` at t+1.
  - Success with fill: the fill writes occupy t+1 to t+M, where M = `MEMORY_REGISTERS`−L, and `done_o` = 1 at t+M+1.
  - Mismatch: `error_o` = 2 at t+1.
- **Byte spacing:** minimum legal spacing is 3 cycles. UART spacing (≥ 10·`BAUD_COUNTS_PER_BIT`) always satisfies this.
- **Reset mid-frame:** takes effect on the next edge. No write is issued from the following cycle on.
- **Simultaneous events:** reset wins over everything. Abort wins over a concurrent `rx_valid_i`.

## Test plan

- **Good even frame, width 4, depth 16, `MSB_FIRST`=1.** Send start, then 0x04, 0xF0, 0xE5, 0x11. Required: writes F@0, 0@1, E@2, 5@3, then 0 at addresses 4 to 15 (12 cycles), then `done_o` = 1 with `error_o` = 0.
- **Odd length.** Send 0x03, 0xDE, 0x80, 0x5D. Required: writes D@0, E@1, 8@2 only (low nibble of 0x80 not written), zero-fill of 3 to 15, `done_o` = 1.
- **Bad checksum.** Send 0x04, 0xF0, 0xE5, 0x12. Required: the 4 payload writes occur, then `error_o` = 2, `done_o` = 0, no fill writes.
- **Bad length.** Send L = 0x00, and separately L = 0x11. Required: `error_o` = 1 and no `mem_we_o`. A new start edge then clears `error_o`.
- **Abort and overrun.**
  - Drop `p_program_i` after the first payload byte. Required: `error_o` = 3, `program_o` = 0.
  - Separately, strobe `rx_valid_i` one cycle after a payload strobe. Required: `error_o` = 3, and the byte is not written.
- **Reset mid-payload, then parameter sweep.** Assert `reset_i` mid-payload. Required: all outputs 0 and no writes. Then with `REGISTER_WIDTH`=8, `MEMORY_REGISTERS`=8 and `ZERO_FILL`=0, send 0x02, 0xAB, 0xCD, 0x64. Required: writes AB@0 and CD@1, then `done_o` = 1.
